riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit: the initiator side of the data-memory request interface, between the core's execute stage and `data_mem`. Converts core loads/stores of byte/halfword/word size into word-aligned memory requests with byte enables and replicated write data. Sign/zero-extends returned load data. Stalls the core until the memory completes.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_req_i` in 1: core requests a memory access; held stable while `core_stall_o`=1.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: funct3 code: LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, right-aligned.
- `core_rd_o` out 32: formatted load data; valid in the completion cycle only.
- `core_stall_o` out 1: core must hold its request.
- `core_misalign_o` out 1: 1-cycle pulse on a misaligned request (see Configuration).
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word-aligned address `{core_addr_i[31:2],2'b00}`.
- `mem_wd_o` out 32: replicated write data.
- `mem_rd_i` in 32: raw memory word.
- `mem_ready_i` in 1: memory completes the outstanding request this cycle.

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE.
- IDLE:
  - If `core_req_i`=1 and the request is not trapped as misaligned: drive `mem_req_o`=1, `core_stall_o`=1.
  - Latch `size_q`=`core_size_i`, `off_q`=`core_addr_i[1:0]` and `we_q`.
  - Go to BUSY.
- BUSY:
  - Keep `mem_req_o`=1 and all mem outputs derived from the held core inputs.
  - If `mem_ready_i`=1: `core_stall_o`=0, `core_rd_o` is valid (load only), next state is IDLE.
  - Otherwise stay in BUSY with `core_stall_o`=1.
- `mem_ready_i` while in IDLE is ignored.
- Byte enables:
  - Byte: `4'b0001<<off`.
  - Half: `off[1] ? 4'b1100 : 4'b0011`.
  - Word: `4'b1111`.
  - Loads drive `mem_be_o`=`4'b1111`.
- Write data:
  - Byte: `{4{wd[7:0]}}`.
  - Half: `{2{wd[15:0]}}`.
  - Word: `wd`.
- Load format, using `size_q` and `off_q`:
  - Select byte `off_q` or half `off_q[1]` from `mem_rd_i`.
  - Sign-extend for codes 0 and 1; zero-extend for codes 4 and 5.
  - Word is passed through unchanged.
- Size codes 3, 6 and 7 are treated as word.
- `core_rd_o`=0 whenever the unit is not in BUSY with `mem_ready_i`=1, and for stores.
- Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.

## Timing
- Minimum access time is 2 cycles (stall high 1 cycle) with `data_mem`, which has 1-cycle read latency and asserts `mem_ready_i` the cycle after the request.
- Back-to-back: a new `core_req_i` in the cycle after completion is issued immediately from IDLE. There is no bubble beyond FSM re-entry.
- `mem_req_o`, `core_stall_o` and `core_rd_o` are combinational from state plus inputs.
- Reset values: state IDLE; `size_q`, `off_q`, `we_q` = 0; `mem_req_o`=0, `core_stall_o`=0, `core_rd_o`=0, `core_misalign_o`=0.
- Reset asserted in BUSY: return to IDLE asynchronously and drop `mem_req_o` immediately. A later `mem_ready_i` is ignored.
- A store completing and a load completing behave identically for stall timing.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned request in IDLE is not issued (`mem_req_o`=0).
  - `core_misalign_o`=1 for that cycle, `core_stall_o`=0, `core_rd_o`=0.
  - The FSM stays in IDLE.
- Undefined:
  - `core_misalign_o` is tied to 0.
  - Misaligned accesses are silently aligned down: half uses `off[1]` only, word ignores `off`.

## Structure
- `riscv_pkg` holds the size constants (`LDST_B`=3'd0, `LDST_H`=1, `LDST_W`=2, `LDST_BU`=4, `LDST_HU`=5) and the FSM state enum `lsu_state_t`.
- Sub-module `lsu_load_format` is the purely combinational extractor (`mem_rd_i`, `size_q`, `off_q` → formatted word). It is instantiated once.

## Test plan
- LW 0x100, memory returns 0xDEADBEEF with ready at cycle+1: `mem_be_o`=1111; stall high 1 cycle; `core_rd_o`=0xDEADBEEF.
- LB 0x103, memory word 0x80FF_0000: `core_rd_o`=0xFFFF_FF80. LBU at the same address gives 0x0000_0080.
- SH 0x102, wd 0x1234ABCD: `mem_addr_o`=0x100, `mem_be_o`=1100, `mem_wd_o`=0xABCDABCD, `mem_we_o`=1.
- `mem_ready_i` delayed 3 cycles:
  - Stall held 4 cycles.
  - `mem_req_o` steady, outputs stable.
  - Then a back-to-back SB 0x105 issues with `mem_be_o`=0010.
- Reset pulse in BUSY: `mem_req_o` and `core_stall_o` drop asynchronously; a later `mem_ready_i` produces `core_rd_o`=0.
- LW 0x102 with `LSU_MISALIGN_TRAP_EN`: `core_misalign_o` pulses 1, `mem_req_o`=0, no stall. Without the macro: issues at 0x100 with `mem_be_o`=1111.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store size codes, LSU state encoding and alignment helper.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

  // Undefined size codes behave as word accesses, so they need full alignment.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: is_misaligned = 1'b0;
      LDST_H, LDST_HU: is_misaligned = off[0];
      default:         is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Extracts and sign/zero-extends the addressed byte or halfword of a memory word.
module lsu_load_format
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = mem_rd_i >> {off_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'h000000, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'h0000, half_sel};
      default: data_o = mem_rd_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned memory requests.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests with a core_misalign_o pulse.
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [1:0]  off;
  logic        trap;
  logic        req_c, stall_c, mis_c;
  logic [31:0] rd_c, fmt_rd;
  logic [3:0]  st_be;

  assign off = core_addr_i[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(core_size_i, off);
`else
  assign trap = 1'b0;
`endif

  lsu_load_format u_fmt (
    .mem_rd_i (mem_rd_i),
    .size_i   (size_q),
    .off_i    (off_q),
    .data_o   (fmt_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    we_d    = we_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    rd_c    = 32'h0;
    case (state_q)
      LSU_IDLE: begin
        if (core_req_i) begin
          if (trap) begin
            mis_c = 1'b1;
          end else begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            size_d  = core_size_i;
            off_d   = off;
            we_d    = core_we_i;
            state_d = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        req_c = 1'b1;
        if (mem_ready_i) begin
          state_d = LSU_IDLE;
          if (!we_q) rd_c = fmt_rd;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted access vanishes at once.
  assign mem_req_o       = req_c & rst_ni;
  assign core_stall_o    = stall_c & rst_ni;
  assign core_misalign_o = mis_c & rst_ni;
  assign core_rd_o       = rst_ni ? rd_c : 32'h0;

  always_comb begin
    case (core_size_i)
      LDST_B, LDST_BU: begin
        st_be    = 4'b0001 << off;
        mem_wd_o = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        mem_wd_o = {2{core_wd_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        mem_wd_o = core_wd_i;
      end
    endcase
  end

  assign mem_be_o   = core_we_i ? st_be : 4'b1111;
  assign mem_we_o   = core_we_i & mem_req_o;
  assign mem_addr_o = {core_addr_i[31:2], 2'b00};

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against a transaction-level model of the access rules.
module tb_riscv_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .core_req_i      (core_req_i),
    .core_we_i       (core_we_i),
    .core_size_i     (core_size_i),
    .core_addr_i     (core_addr_i),
    .core_wd_i       (core_wd_i),
    .core_rd_o       (core_rd_o),
    .core_stall_o    (core_stall_o),
    .core_misalign_o (core_misalign_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wd_o        (mem_wd_o),
    .mem_rd_i        (mem_rd_i),
    .mem_ready_i     (mem_ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  bit          chk_en = 1'b0;
  bit          exp_req, exp_stall, exp_mis, exp_we, exp_done;
  logic [31:0] exp_rd, exp_addr, exp_wd;
  logic [3:0]  exp_be;

  logic [31:0] last_rd, last_addr, last_wd;
  logic [3:0]  last_be;
  logic        last_we;
  int          stall_cnt = 0;
  int          mis_cnt   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] sz, input logic [1:0] a);
    if (!we) return 4'hF;
    if (sz == 3'd0 || sz == 3'd4) return 4'(1 << a);
    if (sz == 3'd1 || sz == 3'd5) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
    if (sz == 3'd0 || sz == 3'd4) return {24'h0, wd[7:0]} * 32'h01010101;
    if (sz == 3'd1 || sz == 3'd5) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (sz)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [2:0] sz, input logic [1:0] a);
    if (sz == 3'd0 || sz == 3'd4) return 1'b0;
    if (sz == 3'd1 || sz == 3'd5) return (a % 2) != 0;
    return a != 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", {31'h0, mem_req_o}, {31'h0, exp_req});
      check("stall", {31'h0, core_stall_o}, {31'h0, exp_stall});
      check("misalign", {31'h0, core_misalign_o}, {31'h0, exp_mis});
      check("core_rd", core_rd_o, exp_rd);
      if (exp_req) begin
        check("mem_addr", mem_addr_o, exp_addr);
        check("mem_be", {28'h0, mem_be_o}, {28'h0, exp_be});
        check("mem_we", {31'h0, mem_we_o}, {31'h0, exp_we});
        if (exp_we) check("mem_wd", mem_wd_o, exp_wd);
      end
    end
    if (mem_req_o) begin
      last_addr = mem_addr_o;
      last_be   = mem_be_o;
      last_wd   = mem_wd_o;
      last_we   = mem_we_o;
    end
    if (exp_done) last_rd = core_rd_o;
    if (core_stall_o) stall_cnt++;
    if (core_misalign_o) mis_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit force_ready);
    for (int i = 0; i < n; i++) begin
      core_req_i  = 1'b0;
      core_we_i   = 1'($urandom_range(0, 1));
      core_size_i = 3'($urandom_range(0, 7));
      core_addr_i = $urandom;
      core_wd_i   = $urandom;
      mem_ready_i = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rd_i    = $urandom;
      exp_req = 0; exp_stall = 0; exp_mis = 0; exp_done = 0; exp_rd = 32'h0;
      step();
    end
  endtask

  // lat = cycles from the request cycle until the cycle mem_ready_i is high.
  task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word, input int lat);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    mem_rd_i    = $urandom;
    exp_addr = addr & 32'hFFFF_FFFC;
    exp_be   = m_be(we, sz, addr[1:0]);
    exp_wd   = m_wd(sz, wd);
    exp_we   = we;
    exp_rd   = 32'h0;
    exp_done = 1'b0;
    if (TRAP && m_misaligned(sz, addr[1:0])) begin
      exp_req = 0; exp_stall = 0; exp_mis = 1;
      step();
      return;
    end
    exp_req = 1; exp_stall = 1; exp_mis = 0;
    step();
    for (int k = 1; k <= lat; k++) begin
      mem_ready_i = (k == lat);
      mem_rd_i    = (k == lat) ? word : $urandom;
      exp_stall   = (k != lat);
      exp_done    = (k == lat);
      exp_rd      = (k == lat && !we) ? m_fmt(sz, addr[1:0], word) : 32'h0;
      step();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h100; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b1;
    exp_req = 0; exp_stall = 0; exp_mis = 0; exp_we = 0; exp_done = 0;
    exp_rd = 0; exp_addr = 0; exp_wd = 0; exp_be = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    check("rst_stall", {31'h0, core_stall_o}, 32'h0);
    check("rst_rd", core_rd_o, 32'h0);
    check("rst_misalign", {31'h0, core_misalign_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk_en = 1'b1;
    idle(2, 1'b0);

    stall_cnt = 0;
    access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    check("lw_rd", last_rd, 32'hDEADBEEF);
    check("lw_be", {28'h0, last_be}, 32'hF);
    check("lw_stall_cycles", stall_cnt, 1);
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 1);
    check("lb_rd", last_rd, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 1);
    check("lbu_rd", last_rd, 32'h00000080);
    idle(1, 1'b1);
    access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 1);
    check("sh_addr", last_addr, 32'h100);
    check("sh_be", {28'h0, last_be}, 32'hC);
    check("sh_wd", last_wd, 32'hABCDABCD);
    check("sh_we", {31'h0, last_we}, 32'h1);

    stall_cnt = 0;
    access(1'b0, 3'd2, 32'h100, 32'h0, 32'h0BADF00D, 4);
    check("slow_stall_cycles", stall_cnt, 4);
    check("slow_rd", last_rd, 32'h0BADF00D);
    access(1'b1, 3'd0, 32'h105, 32'h000000A5, 32'h0, 1);
    check("b2b_sb_be", {28'h0, last_be}, 32'h2);
    check("b2b_sb_wd", last_wd, 32'hA5A5A5A5);
    idle(1, 1'b0);

    // Abort a load mid-flight with an asynchronous reset pulse.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h200;
    mem_ready_i = 1'b0;
    exp_req = 1; exp_stall = 1; exp_mis = 0; exp_we = 0; exp_rd = 0; exp_done = 0;
    exp_addr = 32'h200; exp_be = 4'hF;
    step();
    #2;
    chk_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_busy_req", {31'h0, mem_req_o}, 32'h0);
    check("rst_busy_stall", {31'h0, core_stall_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'hFFFFFFFF;
    exp_req = 0; exp_stall = 0; exp_rd = 0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_late_ready_rd", core_rd_o, 32'h0);
    @(posedge clk);
    #1;
    idle(1, 1'b0);

    mis_cnt = 0;
    access(1'b0, 3'd2, 32'h102, 32'h0, 32'h11223344, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    check("trap_pulses", mis_cnt, 1);
`else
    check("unaligned_lw_addr", last_addr, 32'h100);
    check("unaligned_lw_be", {28'h0, last_be}, 32'hF);
    check("unaligned_lw_rd", last_rd, 32'h11223344);
`endif
    idle(1, 1'b0);

    for (int t = 0; t < 400; t++) begin
      bit          we;
      logic [2:0]  sz;
      we = 1'($urandom_range(0, 1));
      sz = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      access(we, sz, $urandom, $urandom, $urandom, $urandom_range(1, 4));
      idle($urandom_range(0, 2), 1'b0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
